// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: ALU control codes, ALUOp and
// funct encodings, the sequencer state enum and the decoded-op record.
// Subtract is always issued as add with an inverted B operand and carry-in
// of 1, so the ALU's own subtract code (0110) has no constant here.
package alu_pkg;

  localparam logic [3:0] CNTL_AND = 4'b0000;
  localparam logic [3:0] CNTL_OR  = 4'b0001;
  localparam logic [3:0] CNTL_ADD = 4'b0010;
  localparam logic [3:0] CNTL_XOR = 4'b0011;
  localparam logic [3:0] CNTL_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_BAD   = 2'b11;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] cntl;
    logic       invert_b;
    logic       carry_init;
    logic       is_slt;
    logic       ov_en;
    logic       is_logic;
    logic       illegal;
  } dec_op_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational decode of ALUOp/funct/wide into the ALU control record.
// Ports:
//   aluop  in  2   MIPS ALUOp
//   funct  in  6   MIPS funct field (used when aluop = R-type)
//   wide   in  1   64-bit two-pass request
//   op     out     decoded op (control code, B inversion, carry-in, flags)
import alu_pkg::*;

module alu_ctl_decode #(
  parameter bit WIDE_EN = 1'b1
) (
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  input  logic       wide,
  output dec_op_t    op
);

  always_comb begin
    op      = '0;
    op.cntl = CNTL_ADD;
    case (aluop)
      ALUOP_ADD: op.ov_en = 1'b1;
      // aluop 01 is the unsigned-style subtract: never reports overflow
      ALUOP_SUB: begin
        op.invert_b   = 1'b1;
        op.carry_init = 1'b1;
      end
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:  op.ov_en = 1'b1;
          FUNCT_ADDU: op.ov_en = 1'b0;
          FUNCT_SUB: begin
            op.invert_b   = 1'b1;
            op.carry_init = 1'b1;
            op.ov_en      = 1'b1;
          end
          FUNCT_SUBU: begin
            op.invert_b   = 1'b1;
            op.carry_init = 1'b1;
          end
          FUNCT_AND: begin
            op.cntl     = CNTL_AND;
            op.is_logic = 1'b1;
          end
          FUNCT_OR: begin
            op.cntl     = CNTL_OR;
            op.is_logic = 1'b1;
          end
          FUNCT_XOR: begin
            op.cntl     = CNTL_XOR;
            op.is_logic = 1'b1;
          end
          FUNCT_NOR: begin
            op.cntl     = CNTL_NOR;
            op.is_logic = 1'b1;
          end
          // slt runs as a subtract; the sign-corrected MSB becomes the result
          FUNCT_SLT: begin
            op.invert_b   = 1'b1;
            op.carry_init = 1'b1;
            op.is_slt     = 1'b1;
          end
          default: op.illegal = 1'b1;
        endcase
      end
      ALUOP_BAD: op.illegal = 1'b1;
    endcase
    if (wide && (op.is_slt || !WIDE_EN)) op.illegal = 1'b1;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequencer between EX-stage issue and the 32-bit ALU. Accepts one request,
// issues one (narrow) or two chained (wide) ALU passes, and returns a
// masked result with clean flags over a valid/ready handshake.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_aluop/funct/wide/a/b    request fields, sampled only on accept
//   alu_a/b/cntl/carry_in       registered ALU drive (B pre-inverted for sub)
//   alu_out/zero/carry_out/overflow   ALU results (flags may float on logic ops)
//   rsp_valid/rsp_ready         response handshake
//   rsp_result/zero/carry/overflow/illegal   response, held until taken
//
// state   | meaning
// IDLE    | req_ready=1, waiting for a request
// LO      | ALU computing low word; capture it, issue high word if wide
// HI      | ALU computing high word with chained carry; capture it
// RESP    | rsp_valid=1, response held until rsp_ready
import alu_pkg::*;

module alu_sequencer #(
  parameter bit WIDE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_aluop,
  input  logic [5:0]  req_funct,
  input  logic        req_wide,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_cntl,
  output logic        alu_carry_in,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_carry_out,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_carry,
  output logic        rsp_overflow,
  output logic        rsp_illegal
);

  state_t      state;
  dec_op_t     dec;
  logic        wide_q, is_slt_q, is_logic_q, ov_en_q;
  logic [31:0] a_hi_q, b_hi_q;
  logic        carry_clean, ov_clean, slt_bit;

  alu_ctl_decode #(.WIDE_EN(WIDE_EN)) u_decode (
    .aluop (req_aluop),
    .funct (req_funct),
    .wide  (req_wide),
    .op    (dec)
  );

  // AND-gating keeps a floating ALU flag from ever reaching a register
  assign carry_clean = alu_carry_out & ~is_logic_q;
  assign ov_clean    = alu_overflow & ov_en_q;
  assign slt_bit     = alu_out[31] ^ alu_overflow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wide_q       <= 1'b0;
      is_slt_q     <= 1'b0;
      is_logic_q   <= 1'b0;
      ov_en_q      <= 1'b0;
      a_hi_q       <= '0;
      b_hi_q       <= '0;
      req_ready    <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_cntl     <= 4'b0000;
      alu_carry_in <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_illegal  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready    <= 1'b0;
            wide_q       <= req_wide;
            is_slt_q     <= dec.is_slt;
            is_logic_q   <= dec.is_logic;
            ov_en_q      <= dec.ov_en;
            a_hi_q       <= req_a[63:32];
            b_hi_q       <= dec.invert_b ? ~req_b[63:32] : req_b[63:32];
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_illegal  <= dec.illegal;
            if (dec.illegal) begin
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              alu_a        <= req_a[31:0];
              alu_b        <= dec.invert_b ? ~req_b[31:0] : req_b[31:0];
              alu_cntl     <= dec.cntl;
              alu_carry_in <= dec.carry_init;
              state        <= ST_LO;
            end
          end
        end
        ST_LO: begin
          rsp_result[31:0] <= alu_out;
          rsp_zero         <= alu_zero;
          rsp_carry        <= carry_clean;
          rsp_overflow     <= ov_clean;
          if (wide_q) begin
            alu_a        <= a_hi_q;
            alu_b        <= b_hi_q;
            alu_carry_in <= carry_clean;
            state        <= ST_HI;
          end else begin
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
            if (is_slt_q) begin
              rsp_result   <= {63'b0, slt_bit};
              rsp_zero     <= ~slt_bit;
              rsp_carry    <= 1'b0;
              rsp_overflow <= 1'b0;
            end
          end
        end
        ST_HI: begin
          rsp_result[63:32] <= alu_out;
          rsp_zero          <= rsp_zero & alu_zero;
          rsp_carry         <= carry_clean;
          rsp_overflow      <= ov_clean;
          rsp_valid         <= 1'b1;
          state             <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Drives the 32-bit datapath ALU from the other side of its interface.
- Decodes MIPS ALUOp/funct into the ALU control code and registers the operands and CarryIn.
- Captures ALUOut/Zero/CarryOut/Overflow and returns a masked, clean result over a valid/ready handshake.
- Runs 64-bit add/sub as two chained ALU passes using CarryIn/CarryOut; sits between the EX-stage issue logic and the ALU.

Parameters:
- WIDE_EN, 1, enables 64-bit two-pass operations; when 0, req_wide=1 is treated as illegal.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_aluop  in  2  00 add, 01 sub, 10 R-type (use funct), 11 illegal
- req_funct  in  6  MIPS funct field
- req_wide  in  1  64-bit operation
- req_a  in  64  operand A; upper half ignored when narrow
- req_b  in  64  operand B; upper half ignored when narrow
- alu_a  out  32  ALU operand A, registered
- alu_b  out  32  ALU operand B, registered, already inverted for subtract
- alu_cntl  out  4  ALU control, registered
- alu_carry_in  out  1  ALU CarryIn, registered
- alu_out  in  32  ALU result
- alu_zero  in  1  ALU Zero flag
- alu_carry_out  in  1  ALU CarryOut (may be Z for logic ops)
- alu_overflow  in  1  ALU Overflow (may be Z for logic ops)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  64  result; upper 32 bits are 0 when narrow
- rsp_zero  out  1  full-width result == 0
- rsp_carry  out  1  final carry (add: carry out; sub: NOT borrow)
- rsp_overflow  out  1  signed overflow
- rsp_illegal  out  1  undecodable request

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous, active-low.
- Reset: state IDLE; every output 0 (alu_cntl 4'b0000, req_ready 0 while rst_n=0); no response is produced for an operation in flight.
- ALU control codes: add 0010, sub 0110, and 0000, or 0001, xor 0011, nor 1100.
- Decode, aluop 00 and 01: 00 is signed add; 01 is sub (never signals overflow).
- Decode, aluop 10, funct:
  - 100000 add; 100001 addu
  - 100010 sub; 100011 subu
  - 100100 and; 100101 or; 100110 xor; 100111 nor
  - 101010 slt
  - any other funct: illegal.
- Illegal also covers aluop 11, slt with req_wide=1, and req_wide=1 with WIDE_EN=0.
- Subtract is issued as add (0010) with alu_b = ~B and carry_in = 1. The ALU's own sub code is never used.
- Add issues carry_in = 0. Logic ops issue carry_in = 0 and a single cntl across both halves.
- FSM states: IDLE, LO, HI, RESP.
  - IDLE: req_ready=1. On req_valid, latch the request and decode.
    - Illegal request: go to RESP with rsp_illegal=1, result 0, all flags 0.
    - Legal request: load low words into alu_* and go to LO.
  - LO, one cycle: capture alu_out to result[31:0], alu_zero, alu_carry_out.
    - Wide: load high words, carry_in = captured carry, go to HI.
    - Narrow: go to RESP.
  - HI, one cycle: capture alu_out to result[63:32], go to RESP.
  - RESP: rsp_valid=1, all rsp_* held stable until rsp_ready; then go to IDLE. No new request is accepted in the same cycle.
- Latency from the accept cycle T: illegal gives rsp_valid at T+1; narrow at T+2; wide at T+3. Throughput is one op per latency+1 cycles minimum.
- Flags:
  - rsp_zero: narrow = LO alu_zero; wide = LO zero AND HI zero.
  - rsp_carry: alu_carry_out of the final pass for add/sub; 0 for logic ops and slt.
  - rsp_overflow: final-pass alu_overflow only for signed add/sub; 0 for addu/subu, aluop 01, logic ops, slt.
  - The ALU's Z/X on carry/overflow must never reach rsp_* outputs.
- slt: rsp_result = {63'b0, alu_out[31] ^ alu_overflow}; rsp_zero computed on that final result.
- req_* are sampled only in IDLE with req_valid=1. Later changes to req_* do not affect an operation in flight.

Decomposition:
- Package alu_pkg holds:
  - ALU control code constants
  - ALUOp encodings
  - funct constants
  - FSM state enum
  - decoded-op struct (cntl, invert_b, carry_init, is_slt, ov_en, logic, illegal).
- Sub-module alu_ctl_decode: pure combinational req_aluop/req_funct/req_wide into the decoded-op struct. The top holds the FSM and registers.

Test Plan:
- Narrow add: aluop 10, funct 100000, A=0x7FFFFFFF, B=1 -> rsp_valid at T+2, result 0x80000000, overflow 1, carry 0, zero 0.
- Wide sub: aluop 01, wide, A=0x0000000100000000, B=1 -> HI carry_in=0 observed, result 0x00000000FFFFFFFF, carry 1, overflow 0, rsp_valid at T+3.
- slt: funct 101010, A=0xFFFFFFFE (-2), B=1 -> result 1; A=5, B=3 -> result 0; carry and overflow 0.
- Logic op with ALU driving Z on carry/overflow: funct 100110, A=B=0xA5A5A5A5 -> result 0, zero 1, carry 0, overflow 0 (no X/Z).
- Illegal: aluop 10, funct 000000 -> rsp_valid at T+1, rsp_illegal 1, result 0; hold rsp_ready=0 for 5 cycles -> outputs stable, req_ready 0.
- rst_n=0 in HI of a wide add -> next cycle IDLE, rsp_valid 0, alu_* 0; a new request after reset completes normally.
